// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush/redirect sequencing controller
// Optional PIPE_CTRL_PERF_EN adds saturating stall and jump-flush counters.
module pipe_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int FLUSH_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_ld_i,
  input  logic        hold_bus_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [7:0] BOOT_INIT  = 8'(BOOT_CYCLES - 1);
  localparam logic [7:0] FLUSH_INIT = (FLUSH_EXTRA > 0) ? 8'(FLUSH_EXTRA - 1) : 8'd0;
  localparam logic       HAS_FLUSH  = (FLUSH_EXTRA > 0);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
      cnt   <= BOOT_INIT;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    case (state)
      S_BOOT: begin
        hold_pc_o     = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (cnt == 8'd0) state_n = S_RUN;
        else             cnt_n   = cnt - 8'd1;
      end
      S_RUN: begin
        // EX busy outranks a jump: EX never presents a valid jump while holding.
        if (hold_ex_i) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
        end else if (jump_en_i) begin
          jump_en_o     = 1'b1;
          jump_addr_o   = jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (HAS_FLUSH) begin
            state_n = S_FLUSH;
            cnt_n   = FLUSH_INIT;
          end
        end else if (hold_ld_i) begin
          hold_pc_o     = 1'b1;
          hold_if_id_o  = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (hold_bus_i) begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
        end
      end
      S_FLUSH: begin
        // ID/EX hold bubbles here, so only the fetch-side stall matters.
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        hold_pc_o     = hold_bus_i;
        if (cnt == 8'd0) state_n = S_RUN;
        else             cnt_n   = cnt - 8'd1;
      end
      default: begin
        state_n = S_BOOT;
        cnt_n   = BOOT_INIT;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (state == S_RUN && hold_pc_o && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (state == S_RUN && jump_en_o && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It merges hold requests from the EX multi-cycle unit, the ID load-use detector and the instruction bus with the jump request from EX. From these it drives the PC register and the IF/ID and ID/EX pipeline registers with hold, flush and redirect controls. It sits beside the pipeline registers: a flush makes a register load the NOP/zero default, and a hold makes it keep its value.

## Interface
- `BOOT_CYCLES`, default 2: cycles after reset release with the pipeline held and flushed; legal range 1..255.
- `FLUSH_EXTRA`, default 1: extra flush cycles after the jump cycle, covering synchronous-ROM fetch latency; legal range 0..15.
- `clk`  input  1: the only clock; all state changes on its rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `jump_en_i`  input  1: EX resolved a taken branch or jump this cycle.
- `jump_addr_i`  input  32: jump target.
- `hold_ex_i`  input  1: EX multi-cycle unit busy.
- `hold_ld_i`  input  1: load-use hazard detected in ID.
- `hold_bus_i`  input  1: instruction fetch not ready.
- `hold_pc_o`  output  1: PC keeps its value.
- `hold_if_id_o`  output  1: IF/ID keeps its value.
- `hold_id_ex_o`  output  1: ID/EX keeps its value.
- `flush_if_id_o`  output  1: IF/ID loads NOP.
- `flush_id_ex_o`  output  1: ID/EX loads NOP/zero.
- `jump_en_o`  output  1: redirect the PC.
- `jump_addr_o`  output  32: redirect target.
- `stall_cnt_o`  output  32: performance counter, see Configuration.
- `flush_cnt_o`  output  32: performance counter, see Configuration.

## Operation
- The FSM has three states: BOOT, RUN and FLUSH. A down-counter `cnt` is 8 bits wide.
- All control outputs are combinational from the state and the inputs. Only the state, `cnt` and the performance counters are registered.
- **BOOT:**
  - Asserts `hold_pc_o`, `flush_if_id_o` and `flush_id_ex_o`. All other controls are 0.
  - Every input is ignored.
  - When `cnt`==0, go to RUN; otherwise decrement `cnt`.
- **RUN:** the fixed priority is `hold_ex_i` > `jump_en_i` > `hold_ld_i` > `hold_bus_i`.
  - `hold_ex_i`: assert all three holds; flushes 0; `jump_en_o`=0. Any jump request is ignored, because EX only presents a valid jump once it is not holding.
  - `jump_en_i`:
    - Assert `jump_en_o` and both flushes; `jump_addr_o`=`jump_addr_i`; holds 0.
    - If `FLUSH_EXTRA`>0, load `cnt`=`FLUSH_EXTRA`-1 and go to FLUSH.
    - `hold_ld_i` and `hold_bus_i` are ignored this cycle, because the stages they refer to are being flushed.
  - `hold_ld_i`: assert `hold_pc_o`, `hold_if_id_o` and `flush_id_ex_o`, inserting one bubble into EX.
  - `hold_bus_i`: assert `hold_pc_o` and `flush_if_id_o`, inserting one bubble into ID.
  - No request: all outputs are 0.
- **FLUSH:**
  - Asserts both flushes. `hold_pc_o` follows `hold_bus_i`.
  - `jump_en_i`, `hold_ex_i` and `hold_ld_i` are ignored, since EX and ID contain bubbles.
  - When `cnt`==0, go to RUN; otherwise decrement `cnt`. The count advances regardless of `hold_bus_i`.
- `jump_addr_o` is 0 whenever `jump_en_o`=0.
- A hold and a flush of the same register are never asserted together.

## Timing
- **Reset values:**
  - State BOOT, `cnt`=`BOOT_CYCLES`-1.
  - `hold_pc_o`=1, `flush_if_id_o`=1, `flush_id_ex_o`=1.
  - `hold_if_id_o`=0, `hold_id_ex_o`=0, `jump_en_o`=0, `jump_addr_o`=0.
  - Both performance counters 0.
- After `rst` falls, BOOT lasts exactly `BOOT_CYCLES` rising edges, then RUN.
- A jump produces zero-latency redirect and flush in the request cycle, then exactly `FLUSH_EXTRA` further flush cycles. The total jump penalty is 2+`FLUSH_EXTRA` bubbles.
- A load-use hazard stalls for exactly one cycle per asserted cycle of `hold_ld_i`.
- `rst` asserted in any state, including mid-FLUSH, returns the block to BOOT immediately, asynchronously.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments on each RUN cycle with `hold_pc_o`=1.
  - `flush_cnt_o` increments on each accepted jump.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared only by reset.
- `PIPE_CTRL_PERF_EN` undefined: both ports are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- **Boot:** `BOOT_CYCLES`=2, release `rst` with `jump_en_i`=1 held → outputs stay at reset values for 2 edges, then `jump_en_o`=1 in the first RUN cycle.
- **Jump flush:** `FLUSH_EXTRA`=1, pulse `jump_en_i` with `jump_addr_i`=32'h0000_0100 → `jump_en_o`=1 and `jump_addr_o`=32'h100 for one cycle; both flushes high for 2 cycles; `flush_cnt_o`=1.
- **Priority:** `hold_ex_i`=1 together with `jump_en_i`=1 and `hold_ld_i`=1 for 3 cycles → all holds 1, `jump_en_o`=0, flushes 0; `stall_cnt_o`=3.
- **Load-use:** `hold_ld_i` for 1 cycle → `hold_pc_o`=`hold_if_id_o`=`flush_id_ex_o`=1 for exactly 1 cycle, and `hold_id_ex_o`=0.
- **Reset mid-FLUSH:** `FLUSH_EXTRA`=3, assert `rst` 1 cycle after a jump → reset values appear immediately; BOOT is re-entered; counters read 0.
- **Macro off:** with `PIPE_CTRL_PERF_EN` undefined, repeat the jump scenario → `stall_cnt_o`=`flush_cnt_o`=0, and control outputs are identical to the macro-on run.
